// File: rtl/detect_event_monitor_pkg.sv
// Shared types and limits for the detection-event monitor.
package det_mon_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SAT  = 2'd2
    } state_t;

    localparam int CNT_W_DEF  = 4;
    localparam int RUN_W_DEF  = 4;
    localparam int THRESH_DEF = 3;

    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_SAT = sat_max(CNT_W_DEF);
    localparam int RUN_SAT = sat_max(RUN_W_DEF);

endpackage

// File: rtl/detect_event_monitor_if.sv
// Monitor bus: detector-side stimulus (w, z, clr) and monitor status outputs.
interface det_mon_if
    import det_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RUN_W = RUN_W_DEF
);
    logic             w;
    logic             z;
    logic             clr;
    logic             evt_pulse;
    logic [CNT_W-1:0] evt_count;
    logic             ovf;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] max_run;
    logic             alarm;

    modport master (
        output w, z, clr,
        input  evt_pulse, evt_count, ovf, run_len, max_run, alarm
    );

    modport slave (
        input  w, z, clr,
        output evt_pulse, evt_count, ovf, run_len, max_run, alarm
    );
endinterface

// File: rtl/detect_event_monitor_sat_counter.sv
// Saturating up-counter with sync clear and restart-to-one; nxt exposes the value loaded next edge.
module sat_counter
    import det_mon_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         clr,
    input  logic         restart,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic [W-1:0] nxt
);
    localparam logic [W-1:0] SAT = W'(sat_max(W));

    always_comb begin
        nxt = count;
        if (clr)
            nxt = '0;
        else if (restart)
            nxt = W'(1);
        else if (inc && (count != SAT))
            nxt = count + W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            count <= '0;
        else
            count <= nxt;
    end
endmodule

// File: rtl/detect_event_monitor.sv
// Counts rising edges of detector output z and tracks run lengths of w.
// Optional sticky threshold alarm is enabled by defining DET_ALARM_EN.
module detect_event_monitor
    import det_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RUN_W  = RUN_W_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic clk,
    input  logic resetn,
    det_mon_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_SAT_V = CNT_W'(sat_max(CNT_W));

    if (THRESH < 0) begin : g_bad_thresh
        $error("THRESH must be non-negative");
    end

    state_t           state, state_nxt;
    logic             z_q, last_w, evt_pulse, ovf, alarm;
    logic             rise, cnt_inc, cnt_hits_sat, run_restart, run_inc;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RUN_W-1:0] run, run_nxt, max_run;

    // clr masks the edge so a z already high at clear is never counted.
    assign rise         = bus.z & ~z_q & ~bus.clr;
    assign cnt_inc      = rise && (state != S_SAT);
    assign cnt_hits_sat = (cnt_nxt == CNT_SAT_V) && (cnt != CNT_SAT_V);
    assign run_restart  = (state == S_IDLE) || (bus.w != last_w);
    assign run_inc      = ~run_restart;

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (bus.clr),
        .restart (1'b0),
        .inc     (cnt_inc),
        .count   (cnt),
        .nxt     (cnt_nxt)
    );

    sat_counter #(.W(RUN_W)) u_run_cnt (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (bus.clr),
        .restart (run_restart),
        .inc     (run_inc),
        .count   (run),
        .nxt     (run_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = cnt_hits_sat ? S_SAT : S_RUN;
            S_RUN:   if (cnt_hits_sat) state_nxt = S_SAT;
            S_SAT:   state_nxt = S_SAT;
            default: state_nxt = S_IDLE;
        endcase
        if (bus.clr)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            z_q       <= 1'b0;
            last_w    <= 1'b0;
            evt_pulse <= 1'b0;
            ovf       <= 1'b0;
            max_run   <= '0;
        end else begin
            state     <= state_nxt;
            z_q       <= bus.z;
            last_w    <= bus.w;
            evt_pulse <= rise;
            if (bus.clr) begin
                ovf     <= 1'b0;
                max_run <= '0;
            end else begin
                if (cnt_hits_sat)
                    ovf <= 1'b1;
                // Compare against the incoming run length so max_run tracks run_len with no lag.
                if (run_nxt > max_run)
                    max_run <= run_nxt;
            end
        end
    end

`ifdef DET_ALARM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            alarm <= 1'b0;
        else if (bus.clr)
            alarm <= 1'b0;
        else if (32'(cnt_nxt) >= 32'(THRESH))
            alarm <= 1'b1;
    end
`else
    assign alarm = 1'b0;
`endif

    assign bus.evt_pulse = evt_pulse;
    assign bus.evt_count = cnt;
    assign bus.ovf       = ovf;
    assign bus.run_len   = run;
    assign bus.max_run   = max_run;
    assign bus.alarm     = alarm;
endmodule

// File: tb/tb_detect_event_monitor.sv
// Directed bench for detect_event_monitor (CNT_W=4, RUN_W=4, THRESH=3).
module tb_detect_event_monitor;
    import det_mon_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    det_mon_if #(.CNT_W(4), .RUN_W(4)) bus ();

    detect_event_monitor #(.CNT_W(4), .RUN_W(4), .THRESH(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Apply one input vector, then advance to 1 time unit past the next rising edge.
    task automatic cyc(input logic w_i, input logic z_i, input logic clr_i);
        bus.w   = w_i;
        bus.z   = z_i;
        bus.clr = clr_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.w = 1'b0; bus.z = 1'b0; bus.clr = 1'b0;
        #1 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm});
        end
        n_checks++;
        if (dut.state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state, S_IDLE);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_sustained();
        int pulses = 0;
        logic [1:0] zs [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            cyc(zs[i][1], zs[i][0], 1'b0);
            pulses += int'(bus.evt_pulse);
            if (i == 3) begin
                n_checks++;
                if (bus.evt_pulse !== 1'b1) begin
                    n_fail++; $display("FAIL sustained_pulse_edge: got %b want 1", bus.evt_pulse);
                end
            end
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL sustained_pulse_count: got %0d want 1", pulses);
        end
        n_checks++;
        if (bus.evt_count !== 4'd1) begin
            n_fail++; $display("FAIL sustained_evt_count: got %0d want 1", bus.evt_count);
        end
        n_checks++;
        if (bus.run_len !== 4'd5) begin
            n_fail++; $display("FAIL sustained_run_len: got %0d want 5", bus.run_len);
        end
        n_checks++;
        if (bus.max_run !== 4'd5) begin
            n_fail++; $display("FAIL sustained_max_run: got %0d want 5", bus.max_run);
        end
    endtask

    task automatic test_alternating();
        logic [3:0] pat = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc(pat[i], 1'b0, 1'b0);
            n_checks++;
            if (bus.run_len !== 4'd1) begin
                n_fail++; $display("FAIL alt_run_len[%0d]: got %0d want 1", i, bus.run_len);
            end
            n_checks++;
            if (bus.max_run !== 4'd5) begin
                n_fail++; $display("FAIL alt_max_run[%0d]: got %0d want 5", i, bus.max_run);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.run_len !== 4'd5) begin
            n_fail++; $display("FAIL areset_pre_run_len: got %0d want 5", bus.run_len);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm} !== 15'd0) begin
            n_fail++;
            $display("FAIL areset_outputs: got %b want all zero",
                     {bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm});
        end
        n_checks++;
        if (dut.state !== S_IDLE) begin
            n_fail++; $display("FAIL areset_state: got %0d want %0d", dut.state, S_IDLE);
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_count_sat();
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus.evt_pulse !== 1'b1) begin
                n_fail++; $display("FAIL sat_pulse[%0d]: got %b want 1", i, bus.evt_pulse);
            end
            if (i == 14) begin
                n_checks++;
                if ({bus.ovf, bus.evt_count} !== {1'b0, 4'd14}) begin
                    n_fail++; $display("FAIL sat_pre14: got ovf=%b cnt=%0d want ovf=0 cnt=14", bus.ovf, bus.evt_count);
                end
            end
            if (i >= 15) begin
                n_checks++;
                if ({bus.ovf, bus.evt_count} !== {1'b1, 4'd15}) begin
                    n_fail++; $display("FAIL sat_cnt[%0d]: got ovf=%b cnt=%0d want ovf=1 cnt=15", i, bus.ovf, bus.evt_count);
                end
                n_checks++;
                if (dut.state !== S_SAT) begin
                    n_fail++; $display("FAIL sat_state[%0d]: got %0d want %0d", i, dut.state, S_SAT);
                end
            end
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_run_sat();
        cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm} !== 15'd0) begin
            n_fail++;
            $display("FAIL clr_outputs: got %b want all zero",
                     {bus.evt_pulse, bus.evt_count, bus.ovf, bus.run_len, bus.max_run, bus.alarm});
        end
        for (int k = 1; k <= 20; k++) begin
            logic [3:0] exp_run;
            exp_run = (k > 15) ? 4'd15 : 4'(k);
            cyc(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.run_len !== exp_run) begin
                n_fail++; $display("FAIL runsat_len[%0d]: got %0d want %0d", k, bus.run_len, exp_run);
            end
        end
        n_checks++;
        if (bus.max_run !== 4'd15) begin
            n_fail++; $display("FAIL runsat_max: got %0d want 15", bus.max_run);
        end
    endtask

    task automatic test_clear_z_high();
        cyc(1'b1, 1'b1, 1'b0);
        n_checks++;
        if ({bus.evt_pulse, bus.evt_count} !== {1'b1, 4'd1}) begin
            n_fail++; $display("FAIL clrz_pre: got pulse=%b cnt=%0d want pulse=1 cnt=1", bus.evt_pulse, bus.evt_count);
        end
        cyc(1'b1, 1'b1, 1'b1);
        n_checks++;
        if ({bus.evt_pulse, bus.evt_count, bus.run_len, bus.max_run} !== 13'd0) begin
            n_fail++; $display("FAIL clrz_clear: got pulse=%b cnt=%0d run=%0d max=%0d want all 0",
                               bus.evt_pulse, bus.evt_count, bus.run_len, bus.max_run);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            n_checks++;
            if ({bus.evt_pulse, bus.evt_count} !== 5'd0) begin
                n_fail++; $display("FAIL clrz_hold[%0d]: got pulse=%b cnt=%0d want 0", i, bus.evt_pulse, bus.evt_count);
            end
        end
    endtask

    task automatic test_alarm();
        logic exp3;
`ifdef DET_ALARM_EN
        exp3 = 1'b1;
`else
        exp3 = 1'b0;
`endif
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (bus.alarm !== ((i == 3) ? exp3 : 1'b0)) begin
                n_fail++; $display("FAIL alarm_evt[%0d]: got %b want %b", i, bus.alarm, (i == 3) ? exp3 : 1'b0);
            end
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_sustained();
        test_alternating();
        test_async_reset();
        test_count_sat();
        test_run_sat();
        test_clear_z_high();
        test_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
